// File: rtl/mat_mul_host_if.sv
// rtl/mat_mul_host_if.sv - byte source, multiplier strobe bus and result stream of the host
interface mat_mul_host_if;
   logic [7:0]  src_data;
   logic        src_valid;
   logic        src_ready;
   logic [7:0]  mm_a;
   logic        mm_ld;
   logic        mm_rd;
   logic [7:0]  mm_p;
   logic        mm_loaded;
   logic [15:0] res_data;
   logic        res_valid;
   logic        res_ready;

   modport master (
      input  src_data, src_valid, mm_p, mm_loaded, res_ready,
      output src_ready, mm_a, mm_ld, mm_rd, res_data, res_valid
   );

   modport slave (
      output src_data, src_valid, mm_p, mm_loaded, res_ready,
      input  src_ready, mm_a, mm_ld, mm_rd, res_data, res_valid
   );
endinterface

// File: rtl/mat_mul_host.sv
// rtl/mat_mul_host.sv - host-side transfer master for the strobe-driven matrix multiplier
// Loads A then B with mm_ld strobes, runs the mm_rd train, reassembles each C element {hi,lo}.
module mat_mul_host #(
   parameter int N       = 3,
   parameter int HALF    = 2,
   parameter int ACK_TMO = 64
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   mat_mul_host_if.master bus,
   output logic           busy,
   output logic           done,
   output logic           err
);
   localparam int NLD   = 2 * N * N;
   localparam int NMAC  = N * N * N;
   localparam int NRD   = NMAC + 2 * N * N - 1;
   localparam int LD_W  = $clog2(NLD + 1);
   localparam int RD_W  = $clog2(NRD + 1);
   localparam int TMO_W = $clog2(ACK_TMO + 1);
   localparam int PH_W  = $clog2(HALF + 1);

   typedef enum logic [3:0] {
      IDLE, FETCH, LD_HI, LD_LO, ACK, CMP_HI, CMP_LO, RD_HI, RD_LO, EMIT, DONE
   } state_t;

   state_t           state, state_nxt;
   logic [PH_W-1:0]  ph;
   logic [LD_W-1:0]  ld_cnt;
   logic [RD_W-1:0]  rd_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic [1:0]       loaded_sync;
   logic             lo_flag;
   logic [7:0]       hi_byte;
   logic             ph_end, tmo_hit, phased, src_hs, samp;

   assign ph_end  = (ph == PH_W'(HALF - 1));
   assign tmo_hit = (tmo_cnt == TMO_W'(ACK_TMO - 1));
   assign src_hs  = bus.src_valid && bus.src_ready;
   assign samp    = (state == RD_LO) && (ph == '0);
   assign phased  = (state == LD_HI) || (state == LD_LO) || (state == CMP_HI) ||
                    (state == CMP_LO) || (state == RD_HI) || (state == RD_LO);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (start) state_nxt = FETCH;
         FETCH:  if (src_hs) state_nxt = LD_HI;
         LD_HI:  if (ph_end) state_nxt = LD_LO;
         LD_LO:  if (ph_end) state_nxt = (ld_cnt == LD_W'(NLD - 1)) ? ACK : FETCH;
         ACK: begin
            if (loaded_sync[1])
               state_nxt = (NMAC > 1) ? CMP_HI : RD_HI;
            else if (tmo_hit)
               state_nxt = IDLE;
         end
         CMP_HI: if (ph_end) state_nxt = CMP_LO;
         CMP_LO: if (ph_end) state_nxt = (rd_cnt == RD_W'(NMAC - 2)) ? RD_HI : CMP_HI;
         RD_HI:  if (ph_end) state_nxt = RD_LO;
         RD_LO:  if (ph_end) state_nxt = lo_flag ? EMIT : RD_HI;
         // the strobe train is frozen here until the pending element is taken
         EMIT: begin
            if (!bus.res_valid || bus.res_ready)
               state_nxt = (rd_cnt == RD_W'(NRD)) ? DONE : RD_HI;
         end
         DONE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         ph          <= '0;
         ld_cnt      <= '0;
         rd_cnt      <= '0;
         tmo_cnt     <= '0;
         loaded_sync <= '0;
         lo_flag     <= 1'b0;
         hi_byte     <= '0;
      end else begin
         state       <= state_nxt;
         loaded_sync <= {loaded_sync[0], bus.mm_loaded};
         if (state_nxt != state)
            ph <= '0;
         else if (phased)
            ph <= ph + PH_W'(1);
         tmo_cnt <= (state == ACK) ? tmo_cnt + TMO_W'(1) : '0;
         if (state == IDLE) begin
            ld_cnt  <= '0;
            rd_cnt  <= '0;
            lo_flag <= 1'b0;
         end
         if (state == LD_LO && ph_end)
            ld_cnt <= ld_cnt + LD_W'(1);
         if ((state == CMP_LO || state == RD_LO) && ph_end)
            rd_cnt <= rd_cnt + RD_W'(1);
         if (state == RD_LO && ph_end)
            lo_flag <= ~lo_flag;
         if (samp && !lo_flag)
            hi_byte <= bus.mm_p;
      end
   end

   // Strobes are registered from the current state, so each rises one cycle into its HI
   // state: mm_a (captured on the FETCH handshake) leads mm_ld by a full cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.src_ready <= 1'b0;
         bus.mm_a      <= '0;
         bus.mm_ld     <= 1'b0;
         bus.mm_rd     <= 1'b0;
         bus.res_data  <= '0;
         bus.res_valid <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
      end else begin
         bus.src_ready <= (state_nxt == FETCH);
         bus.mm_ld     <= (state == LD_HI);
         bus.mm_rd     <= (state == CMP_HI) || (state == RD_HI);
         busy          <= (state_nxt != IDLE);
         done          <= (state_nxt == DONE);
         if (state == FETCH && src_hs)
            bus.mm_a <= bus.src_data;
         if (state == ACK && !loaded_sync[1] && tmo_hit)
            err <= 1'b1;
         if (bus.res_valid && bus.res_ready)
            bus.res_valid <= 1'b0;
         if (samp && lo_flag) begin
            bus.res_data  <= {hi_byte, bus.mm_p};
            bus.res_valid <= 1'b1;
         end
      end
   end
endmodule
